// File: rtl/echip_clk_pattern_ctrl.sv
// echip_clk_pattern_ctrl: frame-aligned pattern sequencer for the modulator/filter clock generator.
// Optional macro ECHIP_CLKCTRL_SETTLE_EN delays active/done by 32 cycles after gen_rstn rises.
module echip_clk_pattern_ctrl #(
  parameter int QUIET_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req_valid,
  input  logic [3:0] req_pattern,
  output logic       req_ready,
  output logic [3:0] cfg_selPattern,
  output logic       gen_rstn,
  output logic       active,
  output logic       done,
  output logic       err_illegal,
  output logic       frame_strobe
);
  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_QUIET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [3:0] LAST_FRAME = 4'(QUIET_FRAMES - 1);

  logic [1:0] state, state_n;
  logic [3:0] phase, phase_n, fcnt, fcnt_n;
  logic [3:0] cur_pat, cur_pat_n, next_pat, next_pat_n;
  logic       rdy_q, boundary, legal, consume, noop, entry;
  logic       on_n, done_n, err_n, active_n;

  assign boundary = (phase == 4'd15);
  assign legal    = (req_pattern != 4'd0) && ((req_pattern & (req_pattern - 4'd1)) == 4'd0);
  // rdy_q is the registered state qualifier; enable is ANDed live so a falling
  // enable can never consume a request on the same edge it takes us to OFF.
  assign req_ready = enable & rdy_q;
  assign consume   = req_valid & req_ready;

  always_comb begin
    state_n    = state;
    cur_pat_n  = cur_pat;
    next_pat_n = next_pat;
    fcnt_n     = fcnt;
    noop       = 1'b0;
    entry      = 1'b0;
    case (state)
      S_OFF: begin
        if (consume && legal) cur_pat_n = req_pattern;
        if (enable) begin
          state_n = S_QUIET;
          fcnt_n  = '0;
        end
      end
      S_QUIET: if (boundary) begin
        if (fcnt == LAST_FRAME) begin
          state_n = S_RUN;
          entry   = 1'b1;
        end else begin
          fcnt_n = fcnt + 4'd1;
        end
      end
      S_RUN: if (consume && legal) begin
        if (req_pattern == cur_pat) begin
          noop = 1'b1;
        end else if (boundary) begin
          // already on a boundary: skip DRAIN so latency stays 16 - phase
          cur_pat_n = req_pattern;
          state_n   = S_QUIET;
          fcnt_n    = '0;
        end else begin
          next_pat_n = req_pattern;
          state_n    = S_DRAIN;
        end
      end
      default: if (boundary) begin
        cur_pat_n = next_pat;
        state_n   = S_QUIET;
        fcnt_n    = '0;
      end
    endcase
    if (!enable) state_n = S_OFF;
    phase_n = (state == S_OFF || state_n == S_OFF) ? 4'd0 : phase + 4'd1;
  end

  assign on_n  = (state_n == S_RUN) || (state_n == S_DRAIN);
  assign err_n = consume & ~legal;

`ifdef ECHIP_CLKCTRL_SETTLE_EN
  logic       settled, settled_n, settle_done;
  logic [4:0] scnt, scnt_n;

  // Counts 32 RUN cycles from gen_rstn rising; a change request leaves RUN and aborts it.
  always_comb begin
    settled_n   = settled;
    scnt_n      = scnt;
    settle_done = 1'b0;
    if (!on_n) begin
      settled_n = 1'b0;
      scnt_n    = '0;
    end else if (state_n == S_RUN && !settled) begin
      if (entry) begin
        scnt_n = '0;
      end else if (scnt == 5'd31) begin
        settled_n   = 1'b1;
        settle_done = 1'b1;
      end else begin
        scnt_n = scnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settled <= 1'b0;
      scnt    <= '0;
    end else begin
      settled <= settled_n;
      scnt    <= scnt_n;
    end
  end

  assign done_n   = enable & (noop | settle_done);
  assign active_n = on_n & settled_n;
`else
  assign done_n   = enable & (noop | entry);
  assign active_n = on_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_OFF;
      phase          <= '0;
      fcnt           <= '0;
      cur_pat        <= 4'b0001;
      next_pat       <= 4'b0001;
      rdy_q          <= 1'b0;
      cfg_selPattern <= '0;
      gen_rstn       <= 1'b0;
      active         <= 1'b0;
      done           <= 1'b0;
      err_illegal    <= 1'b0;
      frame_strobe   <= 1'b0;
    end else begin
      state          <= state_n;
      phase          <= phase_n;
      fcnt           <= fcnt_n;
      cur_pat        <= cur_pat_n;
      next_pat       <= next_pat_n;
      rdy_q          <= (state_n == S_OFF) || (state_n == S_RUN);
      cfg_selPattern <= (state_n == S_OFF) ? 4'd0 : cur_pat_n;
      gen_rstn       <= on_n;
      active         <= active_n;
      done           <= done_n;
      err_illegal    <= err_n;
      frame_strobe   <= (phase_n == 4'd15);
    end
  end
endmodule

// File: tb/tb_echip_clk_pattern_ctrl.sv
// Bench for echip_clk_pattern_ctrl: directed + randomized steps against an event-time reference model.
module tb_echip_clk_pattern_ctrl;
  localparam int QF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_pattern = 4'd0;
  logic       req_ready, gen_rstn, active, done, err_illegal, frame_strobe;
  logic [3:0] cfg_selPattern;

  int nchk = 0, nfail = 0, cyc = 0;

  // Model: times of events rather than states. Quiet window is [m_qs, m_qs+16*QF).
  bit         m_on, m_pend;
  int         m_on_cyc, m_qs, m_pend_at, m_noop_at, m_err_at;
  logic [3:0] m_cur, m_pend_pat;

  echip_clk_pattern_ctrl #(.QUIET_FRAMES(QF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_pattern(req_pattern),
    .req_ready(req_ready), .cfg_selPattern(cfg_selPattern), .gen_rstn(gen_rstn), .active(active),
    .done(done), .err_illegal(err_illegal), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_quiet(input int c);
    return m_on && c >= m_qs && c < m_qs + 16*QF;
  endfunction
  function automatic int m_phase(input int c);
    return (c - m_on_cyc) % 16;
  endfunction
  function automatic bit m_inrun(input int c);
    return m_on && !m_quiet(c) && !m_pend;
  endfunction
  function automatic bit onehot(input logic [3:0] p);
    return p inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  task automatic m_reset();
    m_on = 0; m_pend = 0; m_cur = 4'b0001; m_pend_pat = 4'b0001;
    m_on_cyc = 0; m_qs = 0; m_pend_at = 0; m_noop_at = -1; m_err_at = -1;
  endtask

  task automatic chk_zero(input string tag);
    chk4({tag, "_cfg"}, cfg_selPattern, 4'd0);
    chk1({tag, "_rstn"}, gen_rstn, 1'b0);
    chk1({tag, "_active"}, active, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err_illegal, 1'b0);
    chk1({tag, "_frame"}, frame_strobe, 1'b0);
    chk1({tag, "_ready"}, req_ready, 1'b0);
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model across the edge.
  task automatic step(input bit en, input bit vld, input logic [3:0] pat);
    bit exp_rdy, cons;
    @(negedge clk);
    if (m_pend && cyc >= m_pend_at) begin
      m_cur  = m_pend_pat;
      m_pend = 0;
    end
    chk4("cfg_selPattern", cfg_selPattern, m_on ? m_cur : 4'd0);
    chk1("gen_rstn", gen_rstn, m_on && !m_quiet(cyc));
    chk1("active", active, m_on && !m_quiet(cyc));
    chk1("done", done, m_on && (cyc == m_qs + 16*QF || cyc == m_noop_at));
    chk1("err_illegal", err_illegal, cyc == m_err_at);
    chk1("frame_strobe", frame_strobe, m_on && m_phase(cyc) == 15);
    enable = en; req_valid = vld; req_pattern = pat;
    #1;
    exp_rdy = en && (!m_on || m_inrun(cyc));
    chk1("req_ready", req_ready, exp_rdy);
    cons = vld && exp_rdy;
    if (!en) begin
      m_on = 0; m_pend = 0;
    end else if (!m_on) begin
      m_on = 1; m_on_cyc = cyc + 1; m_qs = cyc + 1;
      if (cons) begin
        if (onehot(pat)) m_cur = pat;
        else m_err_at = cyc + 1;
      end
    end else if (cons) begin
      if (!onehot(pat)) m_err_at = cyc + 1;
      else if (pat == m_cur) m_noop_at = cyc + 1;
      else begin
        m_pend = 1; m_pend_pat = pat;
        m_qs = cyc + 16 - m_phase(cyc);
        m_pend_at = m_qs;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  // Enabled idle; with noise, random requests are thrown in whenever they should be ignored.
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise && !m_inrun(cyc) && m_on && $urandom_range(0, 2) == 0)
        step(1, 1, 4'($urandom_range(0, 15)));
      else
        step(1, 0, 4'd0);
    end
  endtask

  task automatic to_run_phase(input int p);
    for (int i = 0; i < 200 && !(m_inrun(cyc) && m_phase(cyc) == p); i++) step(1, 0, 4'd0);
  endtask

  function automatic logic [3:0] other_pat(input logic [3:0] cur);
    logic [3:0] p;
    p = 4'(4'b0001 << $urandom_range(0, 3));
    if (p == cur) p = {cur[2:0], cur[3]};
    return p;
  endfunction

  initial begin
    logic [3:0] pat;
    m_reset();
    #1;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    cyc = 0;

    // start-up
    step(1, 0, 4'd0);
    idle(40, 0);

    // pattern change at phase 5
    to_run_phase(5);
    step(1, 1, 4'b0100);
    idle(50, 1);

    // illegal and no-op requests
    to_run_phase(7);
    step(1, 1, 4'b0011);
    idle(3, 0);
    step(1, 1, m_cur);
    idle(3, 0);
    step(1, 1, 4'b0000);
    idle(3, 0);

    // change requested right on a boundary
    to_run_phase(15);
    step(1, 1, other_pat(m_cur));
    idle(40, 1);

    // randomized change / illegal requests at random phases
    for (int k = 0; k < 6; k++) begin
      to_run_phase(int'($urandom_range(0, 15)));
      pat = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : other_pat(m_cur);
      step(1, 1, pat);
      idle(50, 1);
    end

    // enable drop mid-QUIET, simultaneous request, re-enable with a request while OFF
    to_run_phase(3);
    step(1, 1, other_pat(m_cur));
    idle(20, 1);
    step(0, 1, other_pat(m_cur));
    step(0, 0, 4'd0);
    step(0, 1, 4'b0010);
    step(1, 1, 4'b1000);
    idle(40, 1);

    // reset mid-DRAIN
    to_run_phase(2);
    step(1, 1, other_pat(m_cur));
    idle(3, 0);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk); enable = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    m_reset();
    @(posedge clk);
    cyc++;
    step(1, 0, 4'd0);
    idle(40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/echip_clk_pattern_ctrl.md
# echip_clk_pattern_ctrl

Sequencer for the on-chip modulator/filter clock generator. It holds the generator's pattern select and its active-low shift-register reset, and changes patterns only at 16-cycle frame boundaries. Around every change it forces a quiet interval in which all generated clocks (phi1, phi2, phi1F, sclk) are held in reset, so no runt or overlapping phases reach the modulator or filters. It runs in the 81.92 MHz serializer clock domain, between the configuration interface and the clock generator.

## Interface

Parameters:
- QUIET_FRAMES, 2: number of full 16-cycle frames the generator is held in reset before release. Legal range 1–15.

Ports:
- clk  in  1  81.92 MHz serializer clock.
- rst  in  1  Asynchronous, active-high reset.
- enable  in  1  Clock generation enable. Level-sensitive.
- req_valid  in  1  Pattern change request.
- req_pattern  in  4  Requested pattern select. Legal values are one-hot only: 0001, 0010, 0100, 1000.
- req_ready  out  1  Request can be consumed.
- cfg_selPattern  out  4  Pattern select to the generator.
- gen_rstn  out  1  Active-low reset to the generator's shift registers.
- active  out  1  Generated clocks are valid.
- done  out  1  One-cycle pulse when a sequence completes.
- err_illegal  out  1  One-cycle pulse when a non-one-hot request is consumed.
- frame_strobe  out  1  High on the cycle where phase = 15.

## Operation

Stored pattern (cur_pat):
- Reset value 0001.

Phase counter:
- 4 bits.
- Held at 0 in OFF; increments every cycle in any other state and wraps 15→0.
- A frame boundary is a cycle with phase = 15.

State machine (states OFF, QUIET, RUN, DRAIN):
- **OFF**
  - Outputs: gen_rstn = 0, cfg_selPattern = 0000, active = 0.
  - A legal request here updates cur_pat directly.
  - enable = 1 → QUIET.
- **QUIET**
  - Outputs: gen_rstn = 0, cfg_selPattern = cur_pat.
  - A frame counter counts boundaries. On the QUIET_FRAMES-th boundary → RUN.
- **RUN**
  - Outputs: gen_rstn = 1, cfg_selPattern = cur_pat.
  - A legal request with a value different from cur_pat is latched into next_pat → DRAIN.
  - A legal request equal to cur_pat is consumed with no state change, and done pulses on the next cycle.
- **DRAIN**
  - Outputs: gen_rstn = 1, cfg_selPattern = cur_pat.
  - On the next boundary: cur_pat ← next_pat → QUIET.

Handshake and error handling:
- req_ready = enable & (state is OFF or RUN). A request is consumed on req_valid & req_ready.
- An illegal request is consumed and dropped: err_illegal pulses and cur_pat and state are unchanged.

Global transitions:
- enable = 0 in any state → OFF on the next edge. Any pending next_pat is discarded.

## Timing

- All outputs are registered.
- Reset values: cfg_selPattern = 0000, gen_rstn = 0, active = 0, done = 0, err_illegal = 0, req_ready = 0, frame_strobe = 0. State = OFF, phase = 0.
- Entering QUIET always coincides with phase = 0, so gen_rstn stays low for exactly QUIET_FRAMES × 16 cycles.
- gen_rstn rises in the first cycle of RUN, which is phase 0. The generator therefore restarts frame-aligned.
- Without SETTLE (see Configuration), active and done assert in that same cycle. done lasts one cycle.
- Change latency: from request consumption at phase p in RUN, gen_rstn falls (16 − p) cycles later.
- enable is sampled high at edge E → first QUIET cycle is E+1.
- Simultaneous enable fall and req_valid: the request is not consumed, because req_ready = 0.
- rst asserted mid-sequence: all outputs go to their reset values immediately and asynchronously, and cur_pat returns to 0001.

## Configuration

ECHIP_CLKCTRL_SETTLE_EN:
- **Defined:** a settle counter holds active = 0 for 32 cycles (2 frames) after gen_rstn rises. active and done then assert together at phase 0. enable = 0 or a new change request during settle aborts the count.
- **Undefined:** active = gen_rstn in RUN/DRAIN, and done asserts on RUN entry.

## Test plan

All scenarios use QUIET_FRAMES = 2 and run without the macro unless stated.

1. **Start-up:** rst → release, enable = 1 at cycle 0 → gen_rstn = 0 and cfg_selPattern = 0001 for cycles 1–32; gen_rstn = 1, active = 1 and a single done pulse at cycle 33.
2. **Pattern change:** in RUN, request 0100 at phase 5 → gen_rstn falls 11 cycles later with cfg_selPattern = 0100, rises 32 cycles after that, and done pulses once.
3. **Illegal and no-op requests:** request 0011 in RUN → err_illegal pulses once with no state change. Request equal to cur_pat → done pulses once and gen_rstn stays 1.
4. **Enable drop mid-QUIET:** enable = 0 → next cycle all outputs = 0 and phase = 0. Re-enable → a full 32-cycle QUIET runs.
5. **Reset mid-DRAIN:** rst asserted → outputs clear immediately and cur_pat = 0001. Re-enable → cfg_selPattern = 0001.
6. **Settle (macro defined):** start-up as in scenario 1 → gen_rstn rises at cycle 33; active and done assert at cycle 65.
